// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Memory-side responder for the CPU sequencer's rd/wr/addr/data bus.
//   Holds a 2^AW x DW RAM. After reset it boots: the RAM is filled from a
//   valid/ready byte stream while the CPU is held in reset. It then moves to
//   RUN, where it answers reads and captures writes.
//
//   Optional feature (macro MEM_WP_EN): in RUN, writes to addresses below
//   WP_LIMIT are dropped and set a sticky wp_err. Boot writes are never
//   protected. When the macro is undefined, wp_err is tied 0.
//
// Ports
//   clk, rst_      clock, asynchronous active-low reset
//   addr           bus address from the address mux
//   rd, wr         read / write strobes from the sequencer
//   data_in        CPU write data
//   data_out       read data (holds its last value when not reading)
//   data_oe        read data valid / bus drive enable (combinational)
//   ld_valid       boot byte valid
//   ld_data        boot byte
//   ld_last        boot byte is the last one
//   ld_ready       boot byte accepted on this edge when ld_valid is high
//   cpu_hold       holds the CPU in reset while high (BOOT)
//   boot_done      high in RUN
//   wp_err         sticky write-protect violation
module bus_mem_responder #(
   parameter int AW       = 5,
   parameter int DW       = 8,
   parameter int RD_LAT   = 1,
   parameter int WP_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic [AW-1:0] addr,
   input  logic          rd,
   input  logic          wr,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   output logic          data_oe,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic          cpu_hold,
   output logic          boot_done,
   output logic          wp_err
);

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

   localparam logic [1:0] LAT = RD_LAT[1:0];

`ifdef MEM_WP_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   state_t        state, state_nxt;
   logic [AW-1:0] ld_addr;
   logic [1:0]    rd_cnt;
   logic          wr_q;
   logic          ld_acc;
   logic          run;
   logic          rd_en;
   logic          rd_go;
   logic          wr_rise;
   logic          wr_blocked;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= BOOT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_acc    = 1'b0;
      cpu_hold  = 1'b1;
      boot_done = 1'b0;
      case (state)
         BOOT: begin
            ld_acc = ld_valid & ld_ready;
            // Last byte flagged, or the table is full: no wrap back to 0.
            if (ld_acc && (ld_last || ld_addr == {AW{1'b1}}))
               state_nxt = RUN;
         end
         RUN: begin
            cpu_hold  = 1'b0;
            boot_done = 1'b1;
         end
         default: state_nxt = BOOT;
      endcase
   end

   // ld_ready is registered: it rises the first edge after reset and
   // falls on the edge that accepts the final byte.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         ld_addr  <= '0;
         ld_ready <= 1'b0;
      end else begin
         ld_ready <= (state_nxt == BOOT);
         if (ld_acc) ld_addr <= ld_addr + 1'b1;
      end
   end

   // ---------------------------------------------------------- RUN side
   assign run        = (state == RUN);
   assign rd_en      = run & rd;
   assign rd_go      = run & rd & ~wr;
   assign wr_rise    = run & wr & ~wr_q;
   assign wr_blocked = WP_ON && (32'(addr) < WP_LIMIT);

   // Combinational so the drive drops in the cycle rd drops, before the
   // CPU side can start driving the bus. A concurrent wr always wins.
   assign data_oe = rd_go & (rd_cnt == LAT);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_q   <= 1'b0;
         rd_cnt <= '0;
      end else begin
         wr_q <= wr;
         if (rd_go) begin
            if (rd_cnt != LAT) rd_cnt <= rd_cnt + 2'd1;
         end else begin
            rd_cnt <= '0;
         end
      end
   end

   // Single write port shared by boot load and RUN writes; the two are
   // mutually exclusive by state. The RAM itself is never reset.
   always_ff @(posedge clk) begin
      if (ld_acc)
         mem[ld_addr] <= ld_data;
      else if (wr_rise && !wr_blocked)
         mem[addr] <= data_in;
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         always_ff @(posedge clk or negedge rst_) begin
            if (!rst_)      data_out <= '0;
            else if (rd_en) data_out <= mem[addr];
         end
      end else begin : g_lat2
         logic [DW-1:0] rd_q;
         always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
               rd_q     <= '0;
               data_out <= '0;
            end else if (rd_en) begin
               rd_q     <= mem[addr];
               data_out <= rd_q;
            end
         end
      end
   endgenerate

`ifdef MEM_WP_EN
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)                      wp_err <= 1'b0;
      else if (wr_rise && wr_blocked) wp_err <= 1'b1;
   end
`else
   assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;
   localparam int N = 32;
`ifdef MEM_WP_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_;
   logic [4:0] addr;
   logic       rd, wr;
   logic [7:0] data_in;
   logic       ld_valid, ld_last;
   logic [7:0] ld_data;

   logic [7:0] do1, do2;
   logic       oe1, rdy1, hold1, done1, wp1;
   logic       oe2, rdy2, hold2, done2, wp2;

   always #5 clk = ~clk;

   bus_mem_responder #(.AW(5), .DW(8), .RD_LAT(1), .WP_LIMIT(8)) dut1 (
      .clk(clk), .rst_(rst_), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
      .data_out(do1), .data_oe(oe1), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(rdy1), .cpu_hold(hold1), .boot_done(done1),
      .wp_err(wp1));

   bus_mem_responder #(.AW(5), .DW(8), .RD_LAT(2), .WP_LIMIT(8)) dut2 (
      .clk(clk), .rst_(rst_), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
      .data_out(do2), .data_oe(oe2), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(rdy2), .cpu_hold(hold2), .boot_done(done2),
      .wp_err(wp2));

   // Reference model: RAM image, which cells are known, boot pointer, mode.
   logic [7:0] mm [N];
   bit         mv [N];
   int         m_addr;
   bit         m_boot;
   bit         m_rdy;
   bit         m_wp;
   int         checks = 0;
   int         errors = 0;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input string tag);
      rst_ = 1'b0; rd = 1'b0; wr = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      #2;
      m_boot = 1'b1; m_rdy = 1'b0; m_wp = 1'b0; m_addr = 0;
      checks++;
      if ({do1, oe1, do2, oe2} !== 18'h0) begin
         errors++;
         $display("FAIL %s reset_data got do1=%h oe1=%b do2=%h oe2=%b exp 0", tag, do1, oe1, do2, oe2);
      end
      checks++;
      if ({rdy1, hold1, done1, wp1, rdy2, hold2, done2, wp2} !== 8'b0100_0100) begin
         errors++;
         $display("FAIL %s reset_status got %b exp 01000100", tag,
                  {rdy1, hold1, done1, wp1, rdy2, hold2, done2, wp2});
      end
      step;
      rst_ = 1'b1;
      step;
      m_rdy = 1'b1;
      checks++;
      if ({rdy1, hold1, done1, rdy2, hold2, done2} !== 6'b110_110) begin
         errors++;
         $display("FAIL %s post_reset_ready got %b exp 110110", tag,
                  {rdy1, hold1, done1, rdy2, hold2, done2});
      end
   endtask

   // Random idle gap (ld_last toggling with ld_valid low), then one offer.
   task automatic boot_byte(input logic [7:0] d, input bit last);
      int idle;
      idle = $urandom_range(0, 2);
      repeat (idle) begin
         ld_valid = 1'b0; ld_data = 8'($urandom); ld_last = 1'($urandom);
         step;
      end
      ld_valid = 1'b1; ld_data = d; ld_last = last;
      #1;
      checks++;
      if (rdy1 !== m_rdy || rdy2 !== m_rdy) begin
         errors++;
         $display("FAIL ld_ready got %b/%b exp %b", rdy1, rdy2, m_rdy);
      end
      step;
      if (m_rdy) begin
         mm[m_addr] = d;
         mv[m_addr] = 1'b1;
         if (last || m_addr == N - 1) begin
            m_boot = 1'b0;
            m_rdy  = 1'b0;
         end
         m_addr++;
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      checks++;
      if ({hold1, done1, hold2, done2} !== {m_boot, !m_boot, m_boot, !m_boot}) begin
         errors++;
         $display("FAIL boot_status got hold/done %b%b %b%b exp %b%b", hold1, done1,
                  hold2, done2, m_boot, !m_boot);
      end
   endtask

   // Hold rd for n cycles at address a; cycle k is the k-th cycle rd is high.
   task automatic rd_op(input int a, input int n);
      addr = 5'(a); rd = 1'b1; wr = 1'b0; data_in = 8'($urandom);
      for (int k = 0; k < n; k++) begin
         #1;
         checks++;
         if (oe1 !== (!m_boot && k >= 1)) begin
            errors++;
            $display("FAIL rd_oe_lat1 a=%0d k=%0d got %b exp %b", a, k, oe1, !m_boot && k >= 1);
         end
         checks++;
         if (oe2 !== (!m_boot && k >= 2)) begin
            errors++;
            $display("FAIL rd_oe_lat2 a=%0d k=%0d got %b exp %b", a, k, oe2, !m_boot && k >= 2);
         end
         if (!m_boot && k >= 1 && mv[a]) begin
            checks++;
            if (do1 !== mm[a]) begin
               errors++;
               $display("FAIL rd_data_lat1 a=%0d k=%0d got %h exp %h", a, k, do1, mm[a]);
            end
         end
         if (!m_boot && k >= 2 && mv[a]) begin
            checks++;
            if (do2 !== mm[a]) begin
               errors++;
               $display("FAIL rd_data_lat2 a=%0d k=%0d got %h exp %h", a, k, do2, mm[a]);
            end
         end
         step;
      end
      rd = 1'b0;
      #1;
      checks++;
      if (oe1 !== 1'b0 || oe2 !== 1'b0) begin
         errors++;
         $display("FAIL rd_oe_drop a=%0d got %b/%b exp 0/0", a, oe1, oe2);
      end
      step;
   endtask

   // wr held n cycles; data_in changes after the first edge so a repeated
   // write would leave the wrong value behind.
   task automatic wr_op(input int a, input logic [7:0] d, input int n, input bit with_rd);
      addr = 5'(a); data_in = d; wr = 1'b1; rd = with_rd;
      for (int k = 0; k < n; k++) begin
         #1;
         if (with_rd) begin
            checks++;
            if (oe1 !== 1'b0 || oe2 !== 1'b0) begin
               errors++;
               $display("FAIL rdwr_oe a=%0d k=%0d got %b/%b exp 0/0", a, k, oe1, oe2);
            end
         end
         step;
         if (k == 0 && !m_boot) begin
            if (WP_ON && a < 8) m_wp = 1'b1;
            else begin
               mm[a] = d;
               mv[a] = 1'b1;
            end
         end
         data_in = ~d;
      end
      wr = 1'b0; rd = 1'b0;
      step;
      checks++;
      if (wp1 !== m_wp || wp2 !== m_wp) begin
         errors++;
         $display("FAIL wp_err a=%0d got %b/%b exp %b", a, wp1, wp2, m_wp);
      end
   endtask

   task automatic test_reset;
      apply_reset("init");
   endtask

   task automatic test_boot_last;
      boot_byte(8'hA1, 1'b0);
      boot_byte(8'hB2, 1'b0);
      boot_byte(8'hC3, 1'b1);
      for (int i = 0; i < 3; i++) rd_op(i, 3);
   endtask

   task automatic test_boot_full;
      logic [7:0] first;
      apply_reset("full");
      first = 8'($urandom);
      boot_byte(first, 1'b0);
      for (int i = 1; i < N; i++) boot_byte(8'($urandom), 1'b0);
      boot_byte(~first, 1'b0);   // 33rd byte: must not be taken
      rd_op(0, 2);
      rd_op(N - 1, 2);
   endtask

   task automatic test_read;
      for (int i = 0; i < 6; i++) rd_op($urandom_range(0, N - 1), $urandom_range(1, 4));
   endtask

   task automatic test_write;
      int a;
      wr_op(9, 8'h5E, 3, 1'b0);
      rd_op(9, 3);
      wr_op(12, 8'h3C, 2, 1'b1);
      rd_op(12, 2);
      for (int i = 0; i < 6; i++) begin
         a = $urandom_range(0, N - 1);
         wr_op(a, 8'($urandom), $urandom_range(1, 3), 1'($urandom));
         rd_op(a, 2);
      end
   endtask

   task automatic test_mid_boot_reset;
      apply_reset("mid1");
      for (int i = 0; i < 4; i++) boot_byte(8'($urandom), 1'b0);
      apply_reset("mid2");
      boot_byte(8'h11, 1'b0);
      boot_byte(8'h22, 1'b1);
      for (int i = 0; i < 4; i++) rd_op(i, 2);
      apply_reset("run");
      rd_op(1, 2);               // ignored in BOOT: no data_oe
      boot_byte(8'h33, 1'b1);
      rd_op(0, 2);
   endtask

   task automatic test_wp;
      wr_op(3, 8'hFF, 1, 1'b0);
      rd_op(3, 2);
      wr_op(8, 8'h6D, 2, 1'b0);
      rd_op(8, 2);
      wr_op(20, 8'h4B, 1, 1'b0);  // wp_err must stay as it was
   endtask

   task automatic test_random;
      int a;
      for (int i = 0; i < 30; i++) begin
         a = $urandom_range(0, N - 1);
         if ($urandom_range(0, 1) == 1)
            wr_op(a, 8'($urandom), $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
         else
            rd_op(a, $urandom_range(1, 4));
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         mm[i] = 8'h00;
         mv[i] = 1'b0;
      end
      rst_ = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; data_in = '0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      #1;
      test_reset;
      test_boot_last;
      test_boot_full;
      test_read;
      test_write;
      test_mid_boot_reset;
      test_wp;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
